// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, funct codes,
// ALU op/select encodings and the decoded control bundle.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] FNT7_BASE = 7'b0000000;
  localparam logic [6:0] FNT7_ALT  = 7'b0100000;

  localparam logic [4:0]  NopRegAddr = 5'd0;
  localparam logic [31:0] ZeroWord   = 32'h0;

  typedef enum logic [4:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,
    ALU_AND, ALU_LUI, ALU_AUIPC, ALU_JAL, ALU_JALR,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
    ALU_BGEU, ALU_LB, ALU_LH, ALU_LW, ALU_LBU,
    ALU_LHU, ALU_SB, ALU_SH, ALU_SW
  } aluop_t;

  typedef enum logic [2:0] {
    SEL_NOP, SEL_ARITH, SEL_LOGIC, SEL_SHIFT,
    SEL_JUMP, SEL_BRANCH, SEL_LOAD, SEL_STORE
  } alusel_t;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_t;

  typedef struct packed {
    aluop_t  aluop;
    alusel_t alusel;
    logic    wreg;
    logic    illegal;
  } ctrl_t;

  function automatic aluop_t arith_op(
    input logic [2:0] f3,
    input logic       alt
  );
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SRL:  return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alusel_t arith_sel(input logic [2:0] f3);
    case (f3)
      F3_SLL, F3_SRL:        return SEL_SHIFT;
      F3_XOR, F3_OR, F3_AND: return SEL_LOGIC;
      default:               return SEL_ARITH;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Instruction format classification and immediate
// extraction, purely combinational.
import decode_stage_pkg::*;

module decode_stage_imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output fmt_t            fmt,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opc;
  logic [31:0] imm32;

  assign opc = inst[6:0];

  always_comb begin
    fmt = FMT_R;
    unique case (1'b1)
      (opc == OPC_LUI) || (opc == OPC_AUIPC): fmt = FMT_U;
      opc == OPC_JAL:                         fmt = FMT_J;
      (opc == OPC_JALR) || (opc == OPC_LOAD)
        || (opc == OPC_OP_IMM):               fmt = FMT_I;
      opc == OPC_STORE:                       fmt = FMT_S;
      opc == OPC_BRANCH:                      fmt = FMT_B;
      default:                                fmt = FMT_R;
    endcase
  end

  always_comb begin
    imm32 = ZeroWord;
    unique case (fmt)
      FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm32 = {{20{inst[31]}}, inst[31:25],
                      inst[11:7]};
      FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7],
                      inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm32 = {inst[31:12], 12'b0};
      FMT_J: imm32 = {{11{inst[31]}}, inst[31],
                      inst[19:12], inst[20],
                      inst[30:21], 1'b0};
      default: imm32 = ZeroWord;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decode, operand forwarding,
// load-use stall and the ID/EX register.
import decode_stage_pkg::*;

module decode_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid_i,
  input  logic [31:0]        inst_i,
  input  logic [XLEN-1:0]    pc_i,
  output logic               id_ready_o,
  output logic               re1_o,
  output logic               re2_o,
  output logic [RADDR_W-1:0] raddr1_o,
  output logic [RADDR_W-1:0] raddr2_o,
  input  logic [XLEN-1:0]    rdata1_i,
  input  logic [XLEN-1:0]    rdata2_i,
  input  logic               ex_we_i,
  input  logic [RADDR_W-1:0] ex_waddr_i,
  input  logic [XLEN-1:0]    ex_wdata_i,
  input  logic               ex_is_load_i,
  input  logic               mem_we_i,
  input  logic [RADDR_W-1:0] mem_waddr_i,
  input  logic [XLEN-1:0]    mem_wdata_i,
  input  logic               flush_i,
  input  logic               ex_ready_i,
  output logic               idex_valid_o,
  output aluop_t             aluop_o,
  output alusel_t            alusel_o,
  output logic [XLEN-1:0]    regdata1_o,
  output logic [XLEN-1:0]    regdata2_o,
  output logic [XLEN-1:0]    storedata_o,
  output logic [XLEN-1:0]    imm_o,
  output logic               wreg_o,
  output logic [RADDR_W-1:0] waddr_o,
  output logic [XLEN-1:0]    pc_o,
  output logic               illegal_o
);

  logic [6:0]         opc, f7;
  logic [2:0]         f3;
  logic [RADDR_W-1:0] rs1, rs2, rd;
  fmt_t               fmt;
  logic [XLEN-1:0]    imm;
  ctrl_t              ctrl;
  logic re1, re2, use_imm, is_store, is_lui;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];
  assign rd  = RADDR_W'(inst_i[11:7]);
  assign rs1 = RADDR_W'(inst_i[19:15]);
  assign rs2 = RADDR_W'(inst_i[24:20]);

  decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (inst_i),
    .fmt  (fmt),
    .imm  (imm)
  );

  always_comb begin
    ctrl = '{aluop: ALU_NOP, alusel: SEL_NOP,
             wreg: 1'b0, illegal: 1'b0};
    re1      = (fmt != FMT_U) && (fmt != FMT_J);
    re2      = (fmt == FMT_R) || (fmt == FMT_S)
               || (fmt == FMT_B);
    use_imm  = (fmt == FMT_I) || (fmt == FMT_S);
    is_store = 1'b0;
    is_lui   = 1'b0;
    case (opc)
      OPC_LUI: begin
        ctrl.aluop  = ALU_LUI;
        ctrl.alusel = SEL_ARITH;
        ctrl.wreg   = 1'b1;
        is_lui      = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.aluop  = ALU_AUIPC;
        ctrl.alusel = SEL_ARITH;
        ctrl.wreg   = 1'b1;
      end
      OPC_JAL: begin
        ctrl.aluop  = ALU_JAL;
        ctrl.alusel = SEL_JUMP;
        ctrl.wreg   = 1'b1;
      end
      OPC_JALR: begin
        ctrl.aluop   = ALU_JALR;
        ctrl.alusel  = SEL_JUMP;
        ctrl.wreg    = 1'b1;
        ctrl.illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl.alusel = SEL_BRANCH;
        case (f3)
          3'b000:  ctrl.aluop = ALU_BEQ;
          3'b001:  ctrl.aluop = ALU_BNE;
          3'b100:  ctrl.aluop = ALU_BLT;
          3'b101:  ctrl.aluop = ALU_BGE;
          3'b110:  ctrl.aluop = ALU_BLTU;
          3'b111:  ctrl.aluop = ALU_BGEU;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.alusel = SEL_LOAD;
        ctrl.wreg   = 1'b1;
        case (f3)
          3'b000:  ctrl.aluop = ALU_LB;
          3'b001:  ctrl.aluop = ALU_LH;
          3'b010:  ctrl.aluop = ALU_LW;
          3'b100:  ctrl.aluop = ALU_LBU;
          3'b101:  ctrl.aluop = ALU_LHU;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.alusel = SEL_STORE;
        is_store    = 1'b1;
        case (f3)
          3'b000:  ctrl.aluop = ALU_SB;
          3'b001:  ctrl.aluop = ALU_SH;
          3'b010:  ctrl.aluop = ALU_SW;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      // Only shift-immediates carry funct7; elsewhere it is imm.
      OPC_OP_IMM: begin
        ctrl.aluop = arith_op(f3,
          (f3 == F3_SRL) && (f7 == FNT7_ALT));
        ctrl.alusel  = arith_sel(f3);
        ctrl.wreg    = 1'b1;
        ctrl.illegal =
          ((f3 == F3_SLL) && (f7 != FNT7_BASE)) ||
          ((f3 == F3_SRL) && (f7 != FNT7_BASE)
            && (f7 != FNT7_ALT));
      end
      OPC_OP: begin
        ctrl.aluop   = arith_op(f3, f7 == FNT7_ALT);
        ctrl.alusel  = arith_sel(f3);
        ctrl.wreg    = 1'b1;
        ctrl.illegal = !((f7 == FNT7_BASE) ||
          ((f7 == FNT7_ALT) &&
           ((f3 == F3_ADD) || (f3 == F3_SRL))));
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (ctrl.illegal) begin
      ctrl.aluop  = ALU_NOP;
      ctrl.alusel = SEL_NOP;
      ctrl.wreg   = 1'b0;
      re1         = 1'b0;
      re2         = 1'b0;
      use_imm     = 1'b0;
      is_store    = 1'b0;
    end
  end

  assign re1_o    = re1;
  assign re2_o    = re2;
  assign raddr1_o = re1 ? rs1 : '0;
  assign raddr2_o = re2 ? rs2 : '0;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic lu_hit, raw_hit, stall, adv;
  logic [XLEN-1:0] src1, src2;

  assign ex_hit1  = re1 && (rs1 != '0) && ex_we_i
                    && (ex_waddr_i == rs1);
  assign ex_hit2  = re2 && (rs2 != '0) && ex_we_i
                    && (ex_waddr_i == rs2);
  assign mem_hit1 = re1 && (rs1 != '0) && mem_we_i
                    && (mem_waddr_i == rs1);
  assign mem_hit2 = re2 && (rs2 != '0) && mem_we_i
                    && (mem_waddr_i == rs2);

  assign lu_hit  = ex_is_load_i && (ex_hit1 || ex_hit2);
  assign raw_hit = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
  assign stall   = if_valid_i &&
                   (lu_hit || (!FWD_EN && raw_hit));

  always_comb begin
    src1 = rdata1_i;
    src2 = rdata2_i;
    if (!re1 || rs1 == '0)
      src1 = '0;
    else if (FWD_EN && ex_hit1 && !ex_is_load_i)
      src1 = ex_wdata_i;
    else if (FWD_EN && mem_hit1)
      src1 = mem_wdata_i;
    if (!re2 || rs2 == '0)
      src2 = '0;
    else if (FWD_EN && ex_hit2 && !ex_is_load_i)
      src2 = ex_wdata_i;
    else if (FWD_EN && mem_hit2)
      src2 = mem_wdata_i;
  end

  assign adv        = ex_ready_i || !idex_valid_o;
  assign id_ready_o = flush_i || (adv && !stall);

  logic wr_en;
  assign wr_en = if_valid_i && ctrl.wreg && (rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_valid_o <= 1'b0;
      aluop_o      <= ALU_NOP;
      alusel_o     <= SEL_NOP;
      regdata1_o   <= '0;
      regdata2_o   <= '0;
      storedata_o  <= '0;
      imm_o        <= '0;
      wreg_o       <= 1'b0;
      waddr_o      <= '0;
      pc_o         <= '0;
      illegal_o    <= 1'b0;
    end else if (flush_i || (adv && stall)) begin
      idex_valid_o <= 1'b0;
      aluop_o      <= ALU_NOP;
      alusel_o     <= SEL_NOP;
      wreg_o       <= 1'b0;
      illegal_o    <= 1'b0;
    end else if (adv) begin
      idex_valid_o <= if_valid_i;
      aluop_o      <= if_valid_i ? ctrl.aluop : ALU_NOP;
      alusel_o     <= if_valid_i ? ctrl.alusel : SEL_NOP;
      regdata1_o   <= is_lui ? '0 : src1;
      regdata2_o   <= use_imm ? imm : src2;
      storedata_o  <= is_store ? src2 : '0;
      imm_o        <= imm;
      wreg_o       <= wr_en;
      waddr_o      <= wr_en ? rd : '0;
      pc_o         <= pc_i;
      illegal_o    <= if_valid_i && ctrl.illegal;
    end
  end

endmodule
